arb_mux_2x1_rr: RTL

//  Round-robin arbitrated 2-to-1 multiplexer with valid/ready handshakes and a registered output.
//  Two producers (A, B) contend for one consumer. The block owns the select decision that the

---
 rtl/arb_mux_2x1_rr.sv | 103 ++++++++++
 1 files changed

// File: rtl/arb_mux_2x1_rr.sv
// Round-robin arbitrated 2:1 mux, valid/ready in and out, registered output.
// Define BURST_LOCK_EN to hold the grant on one channel until its *_last beat.
module arb_mux_2x1_rr #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_b,
  input  logic [WIDTH-1:0] A,
  input  logic             a_valid,
  input  logic             a_last,
  output logic             a_ready,
  input  logic [WIDTH-1:0] B,
  input  logic             b_valid,
  input  logic             b_last,
  output logic             b_ready,
  output logic [WIDTH-1:0] m_out,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             select
);

  logic last_grant;
  logic space;
  logic req_a;
  logic req_b;
  logic grant_a;
  logic load;

  assign space = !m_valid | m_ready;

`ifdef BURST_LOCK_EN
  localparam logic IDLE   = 1'b0;
  localparam logic LOCKED = 1'b1;

  logic state;
  logic lock_a;
  logic beat_last;

  // Mask the request of the channel that does not own an open burst
  always_comb begin
    req_a = a_valid;
    req_b = b_valid;
    if (state == LOCKED) begin
      req_a = a_valid & lock_a;
      req_b = b_valid & !lock_a;
    end
  end

  assign beat_last = grant_a ? a_last : b_last;

  // Lock opens on a non-last beat and closes on the owner's last beat
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      state  <= IDLE;
      lock_a <= 1'b0;
    end else if (load) begin
      state  <= beat_last ? IDLE : LOCKED;
      lock_a <= grant_a;
    end
  end
`else
  logic unused_last;

  assign unused_last = a_last ^ b_last;
  assign req_a = a_valid;
  assign req_b = b_valid;
`endif

  // Tie goes to the channel opposite the last grant (1 = A)
  assign grant_a = req_a & (!req_b | !last_grant);
  assign load    = reset_b & space & (req_a | req_b);
  assign a_ready = load & grant_a;
  assign b_ready = load & !grant_a;

  // Round-robin pointer; with bursts it moves only when a burst closes
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      last_grant <= 1'b0;
`ifdef BURST_LOCK_EN
    end else if (load & beat_last) begin
`else
    end else if (load) begin
`endif
      last_grant <= grant_a;
    end
  end

  // Output register: load a granted beat, or drain when taken
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      m_out   <= '0;
      m_valid <= 1'b0;
      select  <= 1'b0;
    end else if (load) begin
      m_out   <= grant_a ? A : B;
      m_valid <= 1'b1;
      select  <= grant_a;
    end else if (m_ready & m_valid) begin
      m_valid <= 1'b0;
    end
  end

endmodule
